// File: rtl/mux_nx1_stream.sv
// Registered NCH:1 stream selector with valid/ready handshake.
// Fixed-select or round-robin grant feeds a single output register; bad selects raise a sticky error.
module mux_nx1_stream #(
    parameter int DWL = 32,
    parameter int NCH = 4,
    parameter int SWL = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH*DWL-1:0]   In,
    input  logic [NCH-1:0]       InValid,
    output logic [NCH-1:0]       InReady,
    input  logic                 Mode,
    input  logic [SWL-1:0]       Sel,
    output logic [DWL-1:0]       Out,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [SWL-1:0]       OutSel,
    output logic                 SelErr
);

    localparam int             LAST_I   = NCH - 1;
    localparam logic [SWL:0]   NCH_W    = NCH[SWL:0];
    localparam logic [SWL-1:0] LAST_IDX = LAST_I[SWL-1:0];
    localparam logic [SWL-1:0] ONE_IDX  = SWL'(32'd1);

    logic [DWL-1:0] ch_data_s [NCH];
    logic           free_s;
    logic           sel_ok_s;
    logic           grant_vld_s;
    logic [SWL-1:0] grant_idx_s;
    logic           xfer_s;

    logic [DWL-1:0] out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic [SWL-1:0] out_sel_q, out_sel_d;
    logic           sel_err_q, sel_err_d;
    logic [SWL-1:0] ptr_q, ptr_d;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign ch_data_s[k] = In[k*DWL +: DWL];
    end

    assign free_s   = !out_valid_q || OutReady;
    assign sel_ok_s = ({1'b0, Sel} < NCH_W);
    assign xfer_s   = grant_vld_s && free_s && !RST;

    // Grant selection: explicit select, or first valid channel scanning up from ptr_q with wrap at NCH.
    always_comb begin
        logic [SWL:0] idx_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx_v       = '0;
        if (Mode == 1'b0) begin
            if (sel_ok_s && InValid[Sel]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = Sel;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                idx_v = {1'b0, ptr_q} + i[SWL:0];
                if (idx_v >= NCH_W) begin
                    idx_v = idx_v - NCH_W;
                end else begin
                    idx_v = idx_v;
                end
                if (!grant_vld_s && InValid[idx_v[SWL-1:0]]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = idx_v[SWL-1:0];
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // One-hot ready towards the granted producer, only while the slot can take a word.
    always_comb begin
        InReady = '0;
        for (int k = 0; k < NCH; k++) begin
            InReady[k] = xfer_s && (grant_idx_s == k[SWL-1:0]);
        end
    end

    // Next state of output stage, round-robin pointer and sticky select error.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        sel_err_d   = sel_err_q;
        if (xfer_s) begin
            out_d       = ch_data_s[grant_idx_s];
            out_sel_d   = grant_idx_s;
            out_valid_d = 1'b1;
            if (Mode) begin
                ptr_d = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + ONE_IDX;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (!Mode && free_s && !sel_ok_s) begin
            sel_err_d = 1'b1;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign Out      = out_q;
    assign OutValid = out_valid_q;
    assign OutSel   = out_sel_q;
    assign SelErr   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Scoreboard bench for mux_nx1_stream: a 4-channel instance and a 3-channel instance
// (the latter exercises out-of-range select and non-power-of-two wrap).
module tb_mux_nx1_stream;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic         rst, rst_b;
    logic [127:0] in_a;
    logic [3:0]   inv_a, inr_a;
    logic         mode_a, ov_a, ordy_a, serr_a;
    logic [1:0]   sel_a, osel_a;
    logic [31:0]  out_a;

    logic [95:0]  in_b;
    logic [2:0]   inv_b, inr_b;
    logic         mode_b, ov_b, ordy_b, serr_b;
    logic [1:0]   sel_b, osel_b;
    logic [31:0]  out_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    mux_nx1_stream #(.DWL(32), .NCH(4), .SWL(2)) u_a (
        .CLK(clk), .RST(rst), .In(in_a), .InValid(inv_a), .InReady(inr_a),
        .Mode(mode_a), .Sel(sel_a), .Out(out_a), .OutValid(ov_a),
        .OutReady(ordy_a), .OutSel(osel_a), .SelErr(serr_a)
    );

    mux_nx1_stream #(.DWL(32), .NCH(3), .SWL(2)) u_b (
        .CLK(clk), .RST(rst_b), .In(in_b), .InValid(inv_b), .InReady(inr_b),
        .Mode(mode_b), .Sel(sel_b), .Out(out_b), .OutValid(ov_b),
        .OutReady(ordy_b), .OutSel(osel_b), .SelErr(serr_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: every word the consumer takes must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && ov_a && ordy_a) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL mon_a: unexpected word %0h sel %0d, expected none", out_a, osel_a);
            end else begin
                e_a = q_a.pop_front();
                if (out_a !== e_a.d || osel_a !== e_a.s) begin
                    n_fail++;
                    $display("FAIL mon_a: got %0h/%0d expected %0h/%0d", out_a, osel_a, e_a.d, e_a.s);
                end
            end
        end
    end

    // Monitor B: same scoreboard check for the 3-channel instance.
    always @(negedge clk) begin
        if (!rst_b && ov_b && ordy_b) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL mon_b: unexpected word %0h sel %0d, expected none", out_b, osel_b);
            end else begin
                e_b = q_b.pop_front();
                if (out_b !== e_b.d || osel_b !== e_b.s) begin
                    n_fail++;
                    $display("FAIL mon_b: got %0h/%0d expected %0h/%0d", out_b, osel_b, e_b.d, e_b.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        in_a = '0; inv_a = 4'hF; mode_a = 1'b0; sel_a = 2'd0; ordy_a = 1'b1;
        in_b = '0; inv_b = 3'h7; mode_b = 1'b0; sel_b = 2'd0; ordy_b = 1'b1;

        // Reset with every channel valid
        @(negedge clk);
        chk("rst_inready", inr_a, 64'h0);
        chk("rst_out", out_a, 64'h0);
        chk("rst_outvalid", ov_a, 64'h0);
        chk("rst_outsel", osel_a, 64'h0);
        chk("rst_selerr", serr_a, 64'h0);
        chk("rst_b_inready", inr_b, 64'h0);
        step();
        rst = 1'b0; inv_a = 4'h0; inv_b = 3'h0;

        // Fixed select of channel 2
        in_a[2*32 +: 32] = 32'hDEADBEEF; sel_a = 2'd2; inv_a = 4'b0100;
        q_a.push_back('{d: 32'hDEADBEEF, s: 2'd2});
        @(negedge clk);
        chk("fixed_inready", inr_a, 64'h4);
        step();
        inv_a = 4'h0;
        @(negedge clk);
        chk("fixed_out", out_a, 64'hDEADBEEF);
        chk("fixed_outsel", osel_a, 64'h2);
        chk("fixed_outvalid", ov_a, 64'h1);
        step();

        // Back-pressure: 0x11 held three cycles while channel 1 waits with 0x22
        in_a[0 +: 32] = 32'h11; sel_a = 2'd0; inv_a = 4'b0001; ordy_a = 1'b0;
        q_a.push_back('{d: 32'h11, s: 2'd0});
        step();
        in_a[1*32 +: 32] = 32'h22; sel_a = 2'd1; inv_a = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_out", out_a, 64'h11);
            chk("bp_hold_inready", inr_a, 64'h0);
            chk("bp_hold_valid", ov_a, 64'h1);
            step();
        end
        ordy_a = 1'b1;
        q_a.push_back('{d: 32'h22, s: 2'd1});
        @(negedge clk);
        chk("bp_release_inready", inr_a, 64'h2);
        step();
        inv_a = 4'h0;
        @(negedge clk);
        chk("bp_nogap_out", out_a, 64'h22);
        chk("bp_nogap_valid", ov_a, 64'h1);
        step();

        // Round-robin fairness with all four valid
        mode_a = 1'b1;
        for (int k = 0; k < 4; k++) in_a[k*32 +: 32] = 32'hA0 + k;
        inv_a = 4'hF;
        q_a.push_back('{d: 32'hA0, s: 2'd0});
        q_a.push_back('{d: 32'hA1, s: 2'd1});
        q_a.push_back('{d: 32'hA2, s: 2'd2});
        q_a.push_back('{d: 32'hA3, s: 2'd3});
        q_a.push_back('{d: 32'hA0, s: 2'd0});
        @(negedge clk);
        chk("rr_first_inready", inr_a, 64'h1);
        for (int c = 0; c < 5; c++) @(posedge clk);
        #1;

        // Pointer is 1; take channel 1 alone to move it to 2, then only 1 and 3 valid
        inv_a = 4'b0010;
        q_a.push_back('{d: 32'hA1, s: 2'd1});
        step();
        inv_a = 4'b1010;
        q_a.push_back('{d: 32'hA3, s: 2'd3});
        q_a.push_back('{d: 32'hA1, s: 2'd1});
        q_a.push_back('{d: 32'hA3, s: 2'd3});
        @(negedge clk);
        chk("rr_skip_inready", inr_a, 64'h8);
        for (int c = 0; c < 3; c++) @(posedge clk);
        #1;
        inv_a = 4'h0;
        for (int c = 0; c < 2; c++) @(posedge clk);
        @(negedge clk);
        chk("a_drained_valid", ov_a, 64'h0);
        chk("a_queue_empty", q_a.size(), 64'h0);
        chk("a_selerr_clear", serr_a, 64'h0);

        // 3-channel instance: select 3 is out of range
        step();
        for (int k = 0; k < 3; k++) in_b[k*32 +: 32] = 32'hB0 + k;
        rst_b = 1'b0; mode_b = 1'b0; sel_b = 2'd3; inv_b = 3'b111;
        @(negedge clk);
        chk("selerr_inready", inr_b, 64'h0);
        step();
        sel_b = 2'd0;
        q_b.push_back('{d: 32'hB0, s: 2'd0});
        @(negedge clk);
        chk("selerr_novalid", ov_b, 64'h0);
        chk("selerr_set", serr_b, 64'h1);
        step();
        mode_b = 1'b1; inv_b = 3'b100;
        q_b.push_back('{d: 32'hB2, s: 2'd2});
        @(negedge clk);
        chk("selerr_sticky", serr_b, 64'h1);
        step();
        // Pointer wrapped 2 -> 0, so channel 0 wins over 1
        inv_b = 3'b011;
        q_b.push_back('{d: 32'hB0, s: 2'd0});
        @(negedge clk);
        chk("wrap_inready", inr_b, 64'h1);
        step();
        inv_b = 3'b000;
        step();
        @(negedge clk);
        chk("b_selerr_before_rst", serr_b, 64'h1);
        chk("b_queue_empty", q_b.size(), 64'h0);
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_selerr_cleared", serr_b, 64'h0);
        chk("b_outvalid_after_rst", ov_b, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_stream.md
# mux_nx1_stream

Registered N-channel data selector with valid/ready handshaking, the parametrised successor to the combinational 3:1 operand muxes in the multicycle datapath. It picks one of NCH input channels per cycle, either by explicit select (fixed mode) or by round-robin arbitration, and registers the winner into a single output stage. An out-of-range select holds the output and raises a sticky error flag instead of inferring a latch. It sits between producer units (ALU result, memory read data, PC+4, immediate path) and a shared consumer register.

## Interface
- DWL, 32, data width per channel
- NCH, 4, number of input channels (2..16)
- SWL, 2, select width; must satisfy 2**SWL >= NCH
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- In  in  NCH*DWL  channel data, channel k at bits [k*DWL +: DWL]
- InValid  in  NCH  per-channel valid
- InReady  out  NCH  per-channel ready (combinational)
- Mode  in  1  0 = fixed select, 1 = round-robin
- Sel  in  SWL  channel index used in fixed mode
- Out  out  DWL  registered output data
- OutValid  out  1  output register holds a word
- OutReady  in  1  consumer accepts word this cycle
- OutSel  out  SWL  index of channel that produced Out
- SelErr  out  1  sticky: fixed-mode Sel >= NCH was presented while slot free

## Operation
- Slot free: Free = !OutValid || OutReady.
- Grant (combinational, only while Free):
  - Fixed mode: grant channel Sel if Sel < NCH and InValid[Sel]; otherwise no grant.
  - Round-robin: scan channels Ptr, Ptr+1, … wrapping modulo NCH; grant first with InValid set; none if all idle.
- InReady[k] = Free && grant == k; at most one bit high. InReady never depends on InValid of the same channel except through the grant.
- Transfer on channel k when InValid[k] && InReady[k]: Out <= In[k], OutSel <= k, OutValid <= 1.
- Free with no grant: OutValid <= 0; Out and OutSel hold last value.
- Not Free (OutValid && !OutReady): Out, OutSel, OutValid hold; all InReady low.
- Ptr (round-robin pointer, SWL bits): on round-robin transfer from k, Ptr <= (k == NCH-1) ? 0 : k+1. Unchanged on fixed-mode transfers and idle cycles.
- SelErr <= 1 when Mode == 0 && Free && Sel >= NCH; cleared only by RST. Word in output register unaffected.
- Mode may change any cycle; takes effect in that cycle's grant. Ptr not reset by mode change.

## Timing
- Reset values: Out = 0, OutValid = 0, OutSel = 0, SelErr = 0, Ptr = 0; InReady = 0 during RST cycle.
- Latency: input accepted at edge N appears on Out/OutValid after edge N (1 cycle).
- Throughput: one word per cycle when OutReady held high (accept and drain in same cycle).
- Back-pressure: OutReady low with OutValid high stalls; word held indefinitely, no loss, no duplication.
- Simultaneous valid on several channels: exactly one transferred per cycle; round-robin guarantees each persistently-valid channel granted within NCH cycles.
- Reset mid-operation: held output word discarded, OutValid 0 on next cycle, Ptr back to 0.
- NCH not a power of two: Ptr wraps NCH-1 -> 0; indices >= NCH never granted.

## Test plan
- Reset: assert RST with all InValid = 1 -> after edge Out = 0, OutValid = 0, OutSel = 0, SelErr = 0, InReady = 0.
- Fixed mode, NCH=4: Sel = 2, In[2] = 0xDEADBEEF valid, OutReady = 1 -> next cycle Out = 0xDEADBEEF, OutSel = 2, OutValid = 1; InReady = 4'b0100 during accept.
- Back-pressure: word 0x11 held with OutReady = 0 for 3 cycles while In[1] = 0x22 valid -> Out stays 0x11, InReady = 0; OutReady = 1 -> 0x22 loaded same edge, no gap.
- Round-robin fairness: all four channels valid continuously, OutReady = 1 -> OutSel sequence 0,1,2,3,0; Ptr wraps to 0.
- Round-robin skip: only channels 1 and 3 valid, Ptr = 2 -> grants 3, then 1, then 3.
- Select error, NCH=3, SWL=2: Mode = 0, Sel = 3, slot free -> no grant, OutValid = 0 next cycle, SelErr = 1 and stays 1 after Sel = 0; cleared only by RST.
